// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and imem program loader: takes symbolic fields over
// valid/ready, encodes them and writes one machine word per accepted instruction.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W+1:0] Capacity = (ADDR_W+2)'(2 ** ADDR_W);

  typedef enum logic [2:0] {StIdle, StAccept, StWrite, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          code_q, code_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                last_q, last_d;

  logic [31:0]         enc;
  logic                chk_err;
  logic [1:0]          chk_code;
  logic                fits12, fits13, fits21;
  logic [ADDR_W:0]     count_inc;
  logic                full;

  // Sign-extension tests: all bits above the signed field must match its sign bit.
  assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    enc      = '0;
    chk_err  = 1'b0;
    chk_code = 2'd0;
    case (in_op)
      4'd0: begin
        enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        if (!fits12) begin chk_err = 1'b1; chk_code = 2'd1; end
      end
      4'd1: begin
        enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        if (!fits12) begin chk_err = 1'b1; chk_code = 2'd1; end
      end
      4'd2: begin
        enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1], in_imm[11],
               7'b1100011};
        if (!fits13) begin
          chk_err = 1'b1; chk_code = 2'd1;
        end else if (in_imm[0]) begin
          chk_err = 1'b1; chk_code = 2'd2;
        end
      end
      4'd3: begin
        enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        if (!fits21) begin
          chk_err = 1'b1; chk_code = 2'd1;
        end else if (in_imm[0]) begin
          chk_err = 1'b1; chk_code = 2'd2;
        end
      end
      4'd4, 4'd5, 4'd6, 4'd7: begin
        enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
        case (in_op)
          4'd5:    enc[14:12] = 3'b010;
          4'd6:    enc[14:12] = 3'b111;
          4'd7:    enc[14:12] = 3'b110;
          default: enc[14:12] = 3'b000;
        endcase
        if (!fits12) begin chk_err = 1'b1; chk_code = 2'd1; end
      end
      4'd8: begin
        enc = {in_imm[31:12], in_rd, 7'b0110111};
        if (in_imm[11:0] != 12'd0) begin chk_err = 1'b1; chk_code = 2'd2; end
      end
      default: begin
        chk_err  = 1'b1;
        chk_code = 2'd0;
      end
    endcase
  end

  assign count_inc = count_q + 1'b1;
  assign full      = ((ADDR_W+2)'(BaseAddr) + (ADDR_W+2)'(count_inc)) >= Capacity;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    code_d  = code_q;
    count_d = count_q;
    last_d  = last_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StAccept;
          addr_d  = BaseAddr;
          count_d = '0;
          code_d  = 2'd0;
        end
      end
      StAccept: begin
        if (in_valid) begin
          if (chk_err) begin
            code_d  = chk_code;
            state_d = StErr;
          end else begin
            wdata_d = enc;
            last_d  = in_last;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        addr_d  = addr_q + 1'b1;
        count_d = count_inc;
        if (last_q) begin
          state_d = StDone;
        end else if (full) begin
          code_d  = 2'd3;
          state_d = StErr;
        end else begin
          state_d = StAccept;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= BaseAddr;
      wdata_q <= '0;
      code_q  <= 2'd0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      code_q  <= code_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign in_ready   = (state_q == StAccept);
  assign mem_we     = (state_q == StWrite);
  assign busy       = (state_q == StAccept) || (state_q == StWrite);
  assign done       = (state_q == StDone);
  assign error      = (state_q == StErr);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign err_code   = code_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench: issued instructions queue their expected imem write; monitors
// pop and compare on every mem_we. A second, tiny instance exercises memory-full.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset, start, start_s, in_valid, in_last;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, mem_we, busy, done, error;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  err_code;
  logic [6:0]  word_count;

  logic        rdy_s, we_s, busy_s, done_s, error_s;
  logic [1:0]  addr_s, code_s;
  logic [31:0] wdata_s;
  logic [2:0]  wc_s;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .word_count(word_count)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .in_valid(in_valid), .in_ready(rdy_s),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(wdata_s),
    .busy(busy_s), .done(done_s), .error(error_s), .err_code(code_s), .word_count(wc_s)
  );

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];
  logic [37:0] exp_s_q[$];
  logic [37:0] e_m, e_s;
  logic [5:0]  exp_addr_m, exp_addr_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", mem_addr, mem_wdata);
      end else begin
        e_m = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e_m[37:32]));
        chk("wr_data", mem_wdata, e_m[31:0]);
      end
    end
    if (we_s === 1'b1) begin
      if (exp_s_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write_small: addr 0x%0h data 0x%0h, expected none", addr_s, wdata_s);
      end else begin
        e_s = exp_s_q.pop_front();
        chk("wr_addr_small", 32'(addr_s), 32'(e_s[37:32]));
        chk("wr_data_small", wdata_s, e_s[31:0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_s = 1'b1; else start = 1'b1;
    cyc(1);
    start = 1'b0;
    start_s = 1'b0;
  endtask

  // Returns one time unit after the handshake edge, i.e. inside the WRITE (or ERR) cycle.
  task automatic send(input bit sel, input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input bit last, input bit exp_wr, input logic [31:0] word);
    bit hs = 1'b0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      if ((sel ? rdy_s : in_ready) === 1'b1) hs = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: in_ready never seen, expected 1 within 20 cycles");
    end else if (exp_wr) begin
      if (sel) begin exp_s_q.push_back({exp_addr_s, word}); exp_addr_s++; end
      else     begin exp_q.push_back({exp_addr_m, word});   exp_addr_m++; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; start_s = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    exp_addr_m = '0; exp_addr_s = '0;
    cyc(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_word_count", 32'(word_count), 0);
    chk("rst_small_busy", 32'(busy_s), 0);

    // Session 1: ADDI / LW / SW, with stray start pulses that must be ignored.
    pulse_start(0);
    chk("s1_in_ready", 32'(in_ready), 1);
    chk("s1_busy", 32'(busy), 1);
    send(0, 4'd4, 5'd1, 5'd0, 5'd0, 32'd5, 0, 1, 32'h00500093);
    pulse_start(0);
    send(0, 4'd0, 5'd2, 5'd1, 5'd0, 32'd8, 0, 1, 32'h0080A103);
    cyc(1);
    pulse_start(0);
    chk("s1_mid_word_count", 32'(word_count), 2);
    chk("s1_mid_mem_addr", 32'(mem_addr), 2);
    send(0, 4'd1, 5'd0, 5'd1, 5'd2, 32'd4, 1, 1, 32'h0020A223);
    cyc(1);
    chk("s1_done", 32'(done), 1);
    chk("s1_busy_end", 32'(busy), 0);
    chk("s1_in_ready_end", 32'(in_ready), 0);
    chk("s1_word_count", 32'(word_count), 3);

    // Session 2: restart from DONE re-bases the address.
    pulse_start(0);
    exp_addr_m = '0;
    chk("s2_done_cleared", 32'(done), 0);
    chk("s2_mem_addr", 32'(mem_addr), 0);
    chk("s2_word_count", 32'(word_count), 0);
    send(0, 4'd2, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 0, 1, 32'hFE208EE3);
    send(0, 4'd3, 5'd1, 5'd0, 5'd0, 32'd8, 0, 1, 32'h008000EF);
    send(0, 4'd8, 5'd5, 5'd0, 5'd0, 32'h12345000, 1, 1, 32'h123452B7);
    cyc(1);
    chk("s2_done", 32'(done), 1);
    chk("s2_word_count", 32'(word_count), 3);

    // Immediate range: -2048 fits, 2048 does not.
    pulse_start(0);
    exp_addr_m = '0;
    send(0, 4'd4, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 0, 1, 32'h80000093);
    send(0, 4'd4, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 0, 32'h0);
    chk("range_error", 32'(error), 1);
    chk("range_code", 32'(err_code), 1);
    chk("range_in_ready", 32'(in_ready), 0);
    chk("range_word_count", 32'(word_count), 1);
    cyc(2);
    chk("range_error_held", 32'(error), 1);

    // Branch alignment: even offset written, odd offset rejected.
    pulse_start(0);
    exp_addr_m = '0;
    chk("align_error_cleared", 32'(error), 0);
    send(0, 4'd2, 5'd0, 5'd1, 5'd2, 32'd6, 0, 1, 32'h00208363);
    send(0, 4'd2, 5'd0, 5'd1, 5'd2, 32'd3, 0, 0, 32'h0);
    chk("align_error", 32'(error), 1);
    chk("align_code", 32'(err_code), 2);

    // Illegal op code.
    pulse_start(0);
    exp_addr_m = '0;
    send(0, 4'd12, 5'd1, 5'd1, 5'd1, 32'd0, 0, 0, 32'h0);
    chk("illegal_error", 32'(error), 1);
    chk("illegal_code", 32'(err_code), 0);
    chk("illegal_word_count", 32'(word_count), 0);

    // LUI with low bits set, JAL out of 21-bit range.
    pulse_start(0);
    send(0, 4'd8, 5'd5, 5'd0, 5'd0, 32'h12345001, 0, 0, 32'h0);
    chk("lui_align_code", 32'(err_code), 2);
    pulse_start(0);
    send(0, 4'd3, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 0, 0, 32'h0);
    chk("jal_range_code", 32'(err_code), 1);

    // Reset during WRITE: that write shows, nothing after.
    pulse_start(0);
    exp_addr_m = '0;
    send(0, 4'd4, 5'd1, 5'd0, 5'd0, 32'd5, 0, 1, 32'h00500093);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("wrst_mem_we", 32'(mem_we), 0);
    chk("wrst_busy", 32'(busy), 0);
    chk("wrst_in_ready", 32'(in_ready), 0);
    chk("wrst_error", 32'(error), 0);
    chk("wrst_mem_addr", 32'(mem_addr), 0);
    chk("wrst_word_count", 32'(word_count), 0);
    chk("wrst_mem_wdata", mem_wdata, 0);
    cyc(3);

    // Memory full on the 4-word instance.
    pulse_start(1);
    send(1, 4'd4, 5'd3, 5'd4, 5'd0, 32'hFFFF_FFFF, 0, 1, 32'hFFF20193);
    send(1, 4'd5, 5'd3, 5'd4, 5'd0, 32'hFFFF_FFFF, 0, 1, 32'hFFF22193);
    send(1, 4'd6, 5'd3, 5'd4, 5'd0, 32'hFFFF_FFFF, 0, 1, 32'hFFF27193);
    send(1, 4'd7, 5'd3, 5'd4, 5'd0, 32'hFFFF_FFFF, 0, 1, 32'hFFF26193);
    cyc(1);
    chk("full_error", 32'(error_s), 1);
    chk("full_code", 32'(code_s), 3);
    chk("full_in_ready", 32'(rdy_s), 0);
    chk("full_word_count", 32'(wc_s), 4);
    in_op = 4'd4; in_imm = 32'd1; in_last = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_fifth_blocked", 32'(rdy_s), 0);
    end
    in_valid = 1'b0;
    cyc(2);

    chk("queue_main_drained", 32'(exp_q.size()), 0);
    chk("queue_small_drained", 32'(exp_s_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
